// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: drains a TX FIFO one byte at a time and drives an
// asynchronous serial line with 8N1 / 8E1 / 8O1 / 8N2 framing, LSB first.
// The bit period is a fixed integer number of clocks.
//
// FIFO read handshake: the FIFO presents a plain pop port with no valid
// signal. fifo_rd is a one-cycle pop strobe, asserted only while
// fifo_empty was low in IDLE. The popped byte appears on fifo_data in the
// cycle after fifo_rd, and LATCH captures it there. fifo_empty is looked
// at only in IDLE, so the FIFO emptying mid-frame never disturbs a frame.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [2:0] o_dbg_state
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_LATCH  = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [CW-1:0]   r_baud_cnt;
   logic [CW-1:0]   w_baud_next;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift_reg;
   logic            r_parity;
   logic            w_bit_end;
   logic            w_stop_last;

   // Last clock of the current serial bit, and last stop bit of the frame.
   assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
   assign w_stop_last = (r_bit_cnt == STOP_LAST);
   assign w_baud_next = w_bit_end ? '0 : r_baud_cnt + 1'b1;

   assign o_dbg_state = r_state;

   // State register; reset overrides everything else.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; every serial state leaves only on a bit boundary.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (!fifo_empty) begin
               w_next_state = S_READ;
            end
         end
         S_READ:  w_next_state = S_LATCH;
         S_LATCH: w_next_state = S_START;
         S_START: begin
            if (w_bit_end) begin
               w_next_state = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end && (r_bit_cnt == 3'd7)) begin
               w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_next_state = S_STOP;
            end
         end
         S_STOP: begin
            if (w_bit_end && w_stop_last) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs decoded purely from registered state so they cannot glitch.
   always_comb begin
      fifo_rd = 1'b0;
      tx      = 1'b1;
      busy    = (r_state != S_IDLE);
      done    = 1'b0;
      case (r_state)
         S_READ:   fifo_rd = 1'b1;
         S_START:  tx      = 1'b0;
         S_DATA:   tx      = r_shift_reg[0];
         S_PARITY: tx      = r_parity;
         S_STOP:   done    = w_bit_end && w_stop_last;
         default: begin
            tx = 1'b1;
         end
      endcase
   end

   // Datapath: byte capture, parity, baud and bit counters, shifter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift_reg <= '0;
         r_parity    <= 1'b0;
      end else begin
         case (r_state)
            S_LATCH: begin
               r_shift_reg <= fifo_data;
               r_parity    <= (^fifo_data) ^ (PARITY_ODD != 0);
               r_baud_cnt  <= '0;
               r_bit_cnt   <= '0;
            end
            S_START, S_PARITY: begin
               r_baud_cnt <= w_baud_next;
            end
            S_DATA: begin
               r_baud_cnt <= w_baud_next;
               if (w_bit_end) begin
                  // 3-bit counter wraps 7 -> 0, leaving it ready to count stop bits.
                  r_shift_reg <= {1'b0, r_shift_reg[7:1]};
                  r_bit_cnt   <= r_bit_cnt + 3'd1;
               end
            end
            S_STOP: begin
               r_baud_cnt <= w_baud_next;
               if (w_bit_end) begin
                  r_bit_cnt <= w_stop_last ? 3'd0 : r_bit_cnt + 3'd1;
               end
            end
            default: begin
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) share
// one clock, reset and FIFO model; sel picks which instance the FIFO feeds.
module tb_uart_tx_serializer;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       hold = 1'b1;
   logic [3:0] fifo_empty;
   logic [7:0] fifo_data;
   logic [3:0] fifo_rd_w, tx_w, busy_w, done_w;
   logic [3:0][2:0] state_w;

   // FIFO model state
   logic [7:0] fifo_q[$];
   logic       push_req = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       fifo_empty_v = 1'b1;

   // scoreboard and counters
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int rd_cnt = 0;
   int rd_dbl = 0;
   int done_cnt = 0;
   logic rd_prev = 1'b0;

   // captured waveform, index 0 = first cycle with tx low
   logic tr_tx   [0:1023];
   logic tr_done [0:1023];
   logic tr_busy [0:1023];

   always #5 clk = ~clk;

   assign fifo_empty = (fifo_empty_v || hold) ? 4'hF : ~(4'b0001 << sel);

   uart_tx_serializer #(.CLKS_PER_BIT(CPB)) u_dut_8n1 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .o_dbg_state(state_w[0]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_8e1 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .o_dbg_state(state_w[1]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_8o1 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .o_dbg_state(state_w[2]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut_8n2 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty[3]), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]),
      .o_dbg_state(state_w[3]));

   // FIFO model: pop on fifo_rd (data next cycle), push on request.
   always @(posedge clk) begin
      if (fifo_rd_w[sel] && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      if (push_req) fifo_q.push_back(push_data);
      fifo_empty_v <= (fifo_q.size() == 0);
   end

   // Monitor: running counts of pops, back-to-back pops and done pulses.
   always @(negedge clk) begin
      if (fifo_rd_w[sel]) rd_cnt = rd_cnt + 1;
      if (fifo_rd_w[sel] && rd_prev) rd_dbl = rd_dbl + 1;
      rd_prev = fifo_rd_w[sel];
      if (done_w[sel]) done_cnt = done_cnt + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      push_data = b;
      push_req  = 1'b1;
      @(negedge clk);
      push_req  = 1'b0;
   endtask

   // Wait for tx to fall on the selected instance, then record ncyc cycles.
   task automatic capture(input int ncyc, output bit to);
      int waited;
      waited = 0;
      to = 1'b0;
      @(negedge clk);
      while (tx_w[sel] !== 1'b0 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 3000) begin
         to = 1'b1;
         return;
      end
      for (int i = 0; i < ncyc; i++) begin
         tr_tx[i]   = tx_w[sel];
         tr_done[i] = done_w[sel];
         tr_busy[i] = busy_w[sel];
         if (i != ncyc - 1) @(negedge clk);
      end
   endtask

   function automatic int ones(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i < hi; i++) if (tr_tx[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic logic [7:0] decode(input int o);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = tr_tx[o + (1 + i) * CPB + CPB / 2];
      return b;
   endfunction

   // samples in the eight data-bit windows that disagree with byte b
   function automatic int bad_samples(input int o, input logic [7:0] b);
      int n = 0;
      for (int i = 0; i < 8; i++)
         for (int c = 0; c < CPB; c++)
            if (tr_tx[o + (1 + i) * CPB + c] !== b[i]) n++;
      return n;
   endfunction

   function automatic int done_first(input int lo, input int hi);
      for (int i = lo; i < hi; i++) if (tr_done[i] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int done_count(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i < hi; i++) if (tr_done[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int busy_count(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i < hi; i++) if (tr_busy[i] === 1'b1) n++;
      return n;
   endfunction

   task automatic test_reset();
      bit to;
      logic [7:0] exp;
      logic [7:0] got;
      sel = 2'd0;
      hold = 1'b1;
      rst = 1'b0;
      push_byte(8'h3C);
      exp_q.push_back(8'h3C);
      hold = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (tx_w[0] !== 1'b1) begin n_bad++; $display("FAIL reset_tx got=%b exp=1", tx_w[0]); end
      n_cmp++; if (fifo_rd_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_rd got=%b exp=0", fifo_rd_w[0]); end
      n_cmp++; if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_w[0]); end
      n_cmp++; if (done_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done_w[0]); end
      n_cmp++; if (state_w[0] !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state_w[0]); end
      // rst driven high here; the next edge samples it and IDLE sees a
      // non-empty FIFO, so the pop strobe occupies the cycle after that edge.
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (fifo_rd_w[0] !== 1'b1) begin n_bad++; $display("FAIL reset_first_rd got=%b exp=1", fifo_rd_w[0]); end
      @(negedge clk);
      n_cmp++; if (fifo_rd_w[0] !== 1'b0) begin n_bad++; $display("FAIL reset_rd_single got=%b exp=0", fifo_rd_w[0]); end
      capture(10 * CPB + 4, to);
      n_cmp++;
      if (to) begin
         n_bad++; $display("FAIL reset_frame timeout got=no_start exp=start");
      end else begin
         got = decode(0);
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         if (got !== exp) begin n_bad++; $display("FAIL reset_frame_byte got=%h exp=%h", got, exp); end
      end
   endtask

   task automatic test_single_8n1();
      bit to;
      int rd0, dc0, v;
      logic [7:0] exp;
      logic [7:0] got;
      sel = 2'd0;
      hold = 1'b1;
      rd0 = rd_cnt;
      dc0 = done_cnt;
      push_byte(8'hA5);
      exp_q.push_back(8'hA5);
      hold = 1'b0;
      capture(10 * CPB + 4, to);
      hold = 1'b1;
      n_cmp++;
      if (to) begin
         n_bad++; $display("FAIL single timeout got=no_start exp=start");
      end else begin
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         got = decode(0);
         if (got !== exp) begin n_bad++; $display("FAIL single_byte got=%h exp=%h", got, exp); end
         v = ones(0, CPB);
         n_cmp++; if (v !== 0) begin n_bad++; $display("FAIL single_start_high_samples got=%0d exp=0", v); end
         v = bad_samples(0, 8'hA5);
         n_cmp++; if (v !== 0) begin n_bad++; $display("FAIL single_data_bad_samples got=%0d exp=0", v); end
         v = ones(9 * CPB, 10 * CPB);
         n_cmp++; if (v !== CPB) begin n_bad++; $display("FAIL single_stop_high got=%0d exp=%0d", v, CPB); end
         v = done_first(0, 10 * CPB + 4);
         n_cmp++; if (v !== 10 * CPB - 1) begin n_bad++; $display("FAIL single_done_pos got=%0d exp=%0d", v, 10 * CPB - 1); end
         v = done_count(0, 10 * CPB + 4);
         n_cmp++; if (v !== 1) begin n_bad++; $display("FAIL single_done_count got=%0d exp=1", v); end
         v = busy_count(0, 10 * CPB + 4);
         n_cmp++; if (v !== 10 * CPB) begin n_bad++; $display("FAIL single_busy_cycles got=%0d exp=%0d", v, 10 * CPB); end
         v = ones(10 * CPB, 10 * CPB + 4);
         n_cmp++; if (v !== 4) begin n_bad++; $display("FAIL single_idle_high got=%0d exp=4", v); end
      end
      n_cmp++; if (rd_cnt - rd0 !== 1) begin n_bad++; $display("FAIL single_rd_count got=%0d exp=1", rd_cnt - rd0); end
      n_cmp++; if (done_cnt - dc0 !== 1) begin n_bad++; $display("FAIL single_done_pulses got=%0d exp=1", done_cnt - dc0); end
   endtask

   task automatic test_parity(input logic [1:0] inst, input logic [7:0] b, input bit odd);
      bit to;
      int v;
      logic exp_par;
      logic [7:0] exp;
      logic [7:0] got;
      exp_par = (^b) ^ odd;
      sel = inst;
      hold = 1'b1;
      push_byte(b);
      exp_q.push_back(b);
      hold = 1'b0;
      capture(11 * CPB + 4, to);
      hold = 1'b1;
      n_cmp++;
      if (to) begin
         n_bad++; $display("FAIL parity timeout inst=%0d got=no_start exp=start", inst);
      end else begin
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         got = decode(0);
         if (got !== exp) begin n_bad++; $display("FAIL parity_byte inst=%0d got=%h exp=%h", inst, got, exp); end
         v = ones(9 * CPB, 10 * CPB);
         n_cmp++;
         if (v !== (exp_par ? CPB : 0)) begin
            n_bad++; $display("FAIL parity_bit inst=%0d byte=%h high_samples got=%0d exp=%0d", inst, b, v, exp_par ? CPB : 0);
         end
         v = done_first(0, 11 * CPB + 4);
         n_cmp++; if (v !== 11 * CPB - 1) begin n_bad++; $display("FAIL parity_frame_len inst=%0d got=%0d exp=%0d", inst, v, 11 * CPB - 1); end
         v = ones(10 * CPB, 11 * CPB);
         n_cmp++; if (v !== CPB) begin n_bad++; $display("FAIL parity_stop inst=%0d got=%0d exp=%0d", inst, v, CPB); end
      end
   endtask

   task automatic test_back_to_back();
      localparam int L = 11 * CPB;  // 1 start + 8 data + 2 stop
      localparam int STRIDE = L + 3;
      bit to;
      int rd0, dbl0, dc0, v, o;
      logic [7:0] exp;
      logic [7:0] got;
      sel = 2'd3;
      hold = 1'b1;
      rd0 = rd_cnt;
      dbl0 = rd_dbl;
      dc0 = done_cnt;
      push_byte(8'h01); exp_q.push_back(8'h01);
      push_byte(8'hFF); exp_q.push_back(8'hFF);
      push_byte(8'h80); exp_q.push_back(8'h80);
      hold = 1'b0;
      capture(2 * STRIDE + L + 4, to);
      hold = 1'b1;
      n_cmp++;
      if (to) begin
         n_bad++; $display("FAIL b2b timeout got=no_start exp=start");
      end else begin
         for (int j = 0; j < 3; j++) begin
            o = j * STRIDE;
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            got = decode(o);
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_byte frame=%0d got=%h exp=%h", j, got, exp); end
            v = ones(o, o + CPB);
            n_cmp++; if (v !== 0) begin n_bad++; $display("FAIL b2b_start frame=%0d high_samples got=%0d exp=0", j, v); end
            v = ones(o + 9 * CPB, o + L);
            n_cmp++; if (v !== 2 * CPB) begin n_bad++; $display("FAIL b2b_stop frame=%0d got=%0d exp=%0d", j, v, 2 * CPB); end
            v = done_first(o, o + STRIDE);
            n_cmp++; if (v !== o + L - 1) begin n_bad++; $display("FAIL b2b_done_pos frame=%0d got=%0d exp=%0d", j, v, o + L - 1); end
            if (j < 2) begin
               v = ones(o + L, o + STRIDE);
               n_cmp++; if (v !== 3) begin n_bad++; $display("FAIL b2b_gap frame=%0d got=%0d exp=3", j, v); end
            end
         end
      end
      n_cmp++; if (rd_cnt - rd0 !== 3) begin n_bad++; $display("FAIL b2b_rd_count got=%0d exp=3", rd_cnt - rd0); end
      n_cmp++; if (rd_dbl - dbl0 !== 0) begin n_bad++; $display("FAIL b2b_rd_double got=%0d exp=0", rd_dbl - dbl0); end
      n_cmp++; if (done_cnt - dc0 !== 3) begin n_bad++; $display("FAIL b2b_done_pulses got=%0d exp=3", done_cnt - dc0); end
   endtask

   task automatic test_reset_mid_frame();
      bit to;
      int rd0, dc0, v;
      logic [7:0] exp;
      logic [7:0] got;
      sel = 2'd0;
      hold = 1'b1;
      rd0 = rd_cnt;
      push_byte(8'h5A); exp_q.push_back(8'h5A);
      push_byte(8'hC3); exp_q.push_back(8'hC3);
      hold = 1'b0;
      // index 85 lies inside data bit 4 (cycles 80..95 after the fall)
      capture(5 * CPB + 6, to);
      n_cmp++;
      if (to) begin
         n_bad++; $display("FAIL midrst timeout got=no_start exp=start");
      end else begin
         dc0 = done_cnt;
         rst = 1'b0;
         @(negedge clk);
         if (tx_w[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_tx got=%b exp=1", tx_w[0]); end
         n_cmp++; if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy_w[0]); end
         n_cmp++; if (done_w[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b exp=0", done_w[0]); end
         n_cmp++; if (state_w[0] !== 3'd0) begin n_bad++; $display("FAIL midrst_state got=%0d exp=0", state_w[0]); end
         rst = 1'b1;
         // the partially sent byte is abandoned
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         n_cmp++; if (done_cnt - dc0 !== 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt - dc0); end
         capture(10 * CPB + 4, to);
         n_cmp++;
         if (to) begin
            n_bad++; $display("FAIL midrst_fresh timeout got=no_start exp=start");
         end else begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            got = decode(0);
            if (got !== exp) begin n_bad++; $display("FAIL midrst_fresh_byte got=%h exp=%h", got, exp); end
            v = done_first(0, 10 * CPB + 4);
            n_cmp++; if (v !== 10 * CPB - 1) begin n_bad++; $display("FAIL midrst_fresh_done got=%0d exp=%0d", v, 10 * CPB - 1); end
         end
      end
      hold = 1'b1;
      n_cmp++; if (rd_cnt - rd0 !== 2) begin n_bad++; $display("FAIL midrst_rd_count got=%0d exp=2", rd_cnt - rd0); end
   endtask

   task automatic test_empty_fifo();
      int rd0, tx_low, busy_hi;
      sel = 2'd0;
      hold = 1'b0;
      rd0 = rd_cnt;
      tx_low = 0;
      busy_hi = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1) tx_low++;
         if (busy_w[0] !== 1'b0) busy_hi++;
      end
      hold = 1'b1;
      n_cmp++; if (rd_cnt - rd0 !== 0) begin n_bad++; $display("FAIL empty_rd got=%0d exp=0", rd_cnt - rd0); end
      n_cmp++; if (tx_low !== 0) begin n_bad++; $display("FAIL empty_tx_low got=%0d exp=0", tx_low); end
      n_cmp++; if (busy_hi !== 0) begin n_bad++; $display("FAIL empty_busy got=%0d exp=0", busy_hi); end
   endtask

   initial begin
      test_reset();
      test_single_8n1();
      test_parity(2'd1, 8'h07, 1'b0);
      test_parity(2'd2, 8'hA5, 1'b1);
      test_parity(2'd1, 8'hA5, 1'b0);
      test_back_to_back();
      test_reset_mid_frame();
      test_empty_fifo();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
